// File: rtl/frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : frame_receiver
// Description : Receive-side parser for delay-test frames on the MAC RX
//               interface. It extracts the sequence number and the transmit
//               timestamp, computes the one-way delay against the local time
//               base, checks sequence continuity and keeps saturating
//               statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_receiver #(
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          TS_WIDTH  = 32,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 rx_clk,
    input  logic                 reset,
    input  logic                 conf_rx_en,
    input  logic [TS_WIDTH-1:0]  cur_time,
    input  logic [7:0]           mac_rx_data,
    input  logic                 mac_rx_dvld,
    input  logic                 mac_rx_goodframe,
    input  logic                 mac_rx_badframe,
    output logic                 result_valid,
    output logic [15:0]          result_seq,
    output logic [TS_WIDTH-1:0]  result_delay,
    output logic [CNT_WIDTH-1:0] cnt_good,
    output logic [CNT_WIDTH-1:0] cnt_bad,
    output logic [CNT_WIDTH-1:0] cnt_ignored,
    output logic [CNT_WIDTH-1:0] cnt_seq_err
);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_HDR         = 3'd1,
        ST_SEQ         = 3'd2,
        ST_TS          = 3'd3,
        ST_DRAIN       = 3'd4,
        ST_WAIT_STATUS = 3'd5,
        ST_DISCARD     = 3'd6
    } state_t;

    localparam logic [10:0] c_BYTE_ETYPE_HI = 11'd12;
    localparam logic [10:0] c_BYTE_ETYPE_LO = 11'd13;
    localparam logic [10:0] c_BYTE_SEQ_LAST = 11'd15;
    localparam logic [10:0] c_BYTE_TS_LAST  = 11'd19;

    state_t                r_state;
    logic [10:0]           r_byte_cnt;
    logic [7:0]            r_etype_hi;
    logic [15:0]           r_seq;
    logic [15:0]           r_seq_exp;
    logic                  r_seq_init;
    logic [TS_WIDTH-1:0]   r_rx_time;
    logic [TS_WIDTH-1:0]   r_tx_time;
    logic                  r_short;
    logic                  r_not_test;
    logic                  r_discard;

    logic [10:0]           w_byte_cnt_inc;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Byte index of the next byte; holds at 2047 on very long frames
    always_comb begin
        w_byte_cnt_inc = (&r_byte_cnt) ? r_byte_cnt : r_byte_cnt + 11'd1;
    end

    // Frame parser, status handling, result generation and statistics
    always_ff @(posedge rx_clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_byte_cnt   <= 11'd0;
            r_etype_hi   <= 8'd0;
            r_seq        <= 16'd0;
            r_seq_exp    <= 16'd0;
            r_seq_init   <= 1'b0;
            r_rx_time    <= '0;
            r_tx_time    <= '0;
            r_short      <= 1'b0;
            r_not_test   <= 1'b0;
            r_discard    <= 1'b0;
            result_valid <= 1'b0;
            result_seq   <= 16'd0;
            result_delay <= '0;
            cnt_good     <= '0;
            cnt_bad      <= '0;
            cnt_ignored  <= '0;
            cnt_seq_err  <= '0;
        end else begin
            result_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_byte_cnt <= 11'd0;
                    if (mac_rx_dvld) begin
                        // Byte 0 is consumed here; the enable is only looked at now
                        r_rx_time  <= cur_time;
                        r_byte_cnt <= 11'd1;
                        r_short    <= 1'b0;
                        r_not_test <= 1'b0;
                        r_discard  <= !conf_rx_en;
                        r_state    <= conf_rx_en ? ST_HDR : ST_DISCARD;
                    end
                end

                ST_HDR: begin
                    if (mac_rx_dvld) begin
                        r_byte_cnt <= w_byte_cnt_inc;
                        if (r_byte_cnt == c_BYTE_ETYPE_HI) begin
                            r_etype_hi <= mac_rx_data;
                        end
                        if (r_byte_cnt == c_BYTE_ETYPE_LO) begin
                            if ({r_etype_hi, mac_rx_data} == ETHERTYPE) begin
                                r_state <= ST_SEQ;
                            end else begin
                                r_not_test <= 1'b1;
                                r_state    <= ST_DRAIN;
                            end
                        end
                    end else begin
                        r_short <= 1'b1;
                        r_state <= ST_WAIT_STATUS;
                    end
                end

                ST_SEQ: begin
                    if (mac_rx_dvld) begin
                        r_byte_cnt <= w_byte_cnt_inc;
                        r_seq      <= {r_seq[7:0], mac_rx_data};
                        if (r_byte_cnt == c_BYTE_SEQ_LAST) begin
                            r_state <= ST_TS;
                        end
                    end else begin
                        r_short <= 1'b1;
                        r_state <= ST_WAIT_STATUS;
                    end
                end

                ST_TS: begin
                    if (mac_rx_dvld) begin
                        r_byte_cnt <= w_byte_cnt_inc;
                        r_tx_time  <= {r_tx_time[TS_WIDTH-9:0], mac_rx_data};
                        if (r_byte_cnt == c_BYTE_TS_LAST) begin
                            r_state <= ST_DRAIN;
                        end
                    end else begin
                        r_short <= 1'b1;
                        r_state <= ST_WAIT_STATUS;
                    end
                end

                ST_DRAIN, ST_DISCARD: begin
                    // Payload past the timestamp is of no interest
                    if (mac_rx_dvld) begin
                        r_byte_cnt <= w_byte_cnt_inc;
                    end else begin
                        r_state <= ST_WAIT_STATUS;
                    end
                end

                ST_WAIT_STATUS: begin
                    if (mac_rx_badframe) begin
                        // Bad wins when both status pulses arrive together
                        if (!r_discard) begin
                            cnt_bad <= sat_inc(cnt_bad);
                        end
                        r_state <= ST_IDLE;
                    end else if (mac_rx_goodframe) begin
                        if (!r_discard) begin
                            if (r_short || r_not_test) begin
                                cnt_ignored <= sat_inc(cnt_ignored);
                            end else begin
                                cnt_good     <= sat_inc(cnt_good);
                                result_valid <= 1'b1;
                                result_seq   <= r_seq;
                                result_delay <= r_rx_time - r_tx_time;
                                if (r_seq_init && (r_seq != r_seq_exp)) begin
                                    cnt_seq_err <= sat_inc(cnt_seq_err);
                                end
                                r_seq_exp  <= r_seq + 16'd1;
                                r_seq_init <= 1'b1;
                            end
                        end
                        r_state <= ST_IDLE;
                    end else if (mac_rx_dvld) begin
                        // Status never came: abandon the old frame, this byte starts a new one
                        if (!r_discard) begin
                            cnt_ignored <= sat_inc(cnt_ignored);
                        end
                        r_rx_time  <= cur_time;
                        r_byte_cnt <= 11'd1;
                        r_short    <= 1'b0;
                        r_not_test <= 1'b0;
                        r_discard  <= !conf_rx_en;
                        r_state    <= conf_rx_en ? ST_HDR : ST_DISCARD;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_receiver
// Description : Self-checking bench for frame_receiver. Expected delay
//               results are queued as frames are driven and compared when the
//               receiver reports them; counters are checked per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_receiver;

    localparam int c_GOOD = 0;
    localparam int c_BAD  = 1;
    localparam int c_BOTH = 2;
    localparam int c_NONE = 3;

    logic        rx_clk;
    logic        reset;
    logic        conf_rx_en;
    logic [31:0] cur_time;
    logic [7:0]  mac_rx_data;
    logic        mac_rx_dvld;
    logic        mac_rx_goodframe;
    logic        mac_rx_badframe;
    logic        result_valid;
    logic [15:0] result_seq;
    logic [31:0] result_delay;
    logic [15:0] cnt_good;
    logic [15:0] cnt_bad;
    logic [15:0] cnt_ignored;
    logic [15:0] cnt_seq_err;

    typedef struct packed {
        logic [15:0] seq;
        logic [31:0] delay;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    frame_receiver #(
        .ETHERTYPE (16'h88B5),
        .TS_WIDTH  (32),
        .CNT_WIDTH (16)
    ) dut (
        .rx_clk           (rx_clk),
        .reset            (reset),
        .conf_rx_en       (conf_rx_en),
        .cur_time         (cur_time),
        .mac_rx_data      (mac_rx_data),
        .mac_rx_dvld      (mac_rx_dvld),
        .mac_rx_goodframe (mac_rx_goodframe),
        .mac_rx_badframe  (mac_rx_badframe),
        .result_valid     (result_valid),
        .result_seq       (result_seq),
        .result_delay     (result_delay),
        .cnt_good         (cnt_good),
        .cnt_bad          (cnt_bad),
        .cnt_ignored      (cnt_ignored),
        .cnt_seq_err      (cnt_seq_err)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    // Scoreboard: every reported result must match the oldest queued one
    always @(negedge rx_clk) begin
        if (reset && result_valid) begin
            compared++;
            if (sb_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_result: got seq=%h delay=%h, required no result", result_seq, result_delay);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (result_seq !== e.seq || result_delay !== e.delay) begin
                    mismatched++;
                    $display("FAIL result: got seq=%h delay=%h, required seq=%h delay=%h",
                             result_seq, result_delay, e.seq, e.delay);
                end
            end
        end
    end

    // Drive one frame. flip_at: byte index where conf_rx_en is raised;
    // abort_at: byte index where reset is pulsed and the frame abandoned.
    task automatic send_frame(input logic [15:0] et, input logic [15:0] sq, input logic [31:0] ts,
                              input int len, input logic [31:0] rxt, input int status,
                              input bit expect_result, input int flip_at, input int abort_at,
                              input bit check_lat);
        logic [7:0] b;
        if (expect_result) sb_q.push_back({sq, rxt - ts});
        cur_time = rxt;
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) begin
                reset       = 1'b0;
                mac_rx_dvld = 1'b0;
                @(posedge rx_clk); #1;
                reset = 1'b1;
                @(posedge rx_clk); #1;
                return;
            end
            if (i == flip_at) conf_rx_en = 1'b1;
            case (i)
                12:      b = et[15:8];
                13:      b = et[7:0];
                14:      b = sq[15:8];
                15:      b = sq[7:0];
                16:      b = ts[31:24];
                17:      b = ts[23:16];
                18:      b = ts[15:8];
                19:      b = ts[7:0];
                default: b = 8'(i);
            endcase
            mac_rx_dvld = 1'b1;
            mac_rx_data = b;
            @(posedge rx_clk); #1;
            cur_time = rxt + 32'(i + 1);
        end
        mac_rx_dvld = 1'b0;
        @(posedge rx_clk); #1;
        if (status != c_NONE) begin
            mac_rx_goodframe = (status == c_GOOD || status == c_BOTH);
            mac_rx_badframe  = (status == c_BAD  || status == c_BOTH);
            if (check_lat) begin
                @(negedge rx_clk);
                compared++;
                if (result_valid !== 1'b0) begin
                    mismatched++;
                    $display("FAIL latency_early: result_valid=%b in status cycle, required 0", result_valid);
                end
            end
            @(posedge rx_clk); #1;
            mac_rx_goodframe = 1'b0;
            mac_rx_badframe  = 1'b0;
            if (check_lat) begin
                @(negedge rx_clk);
                compared++;
                if (result_valid !== 1'b1) begin
                    mismatched++;
                    $display("FAIL latency: result_valid=%b one cycle after status, required 1", result_valid);
                end
            end
        end
        repeat (3) @(posedge rx_clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; conf_rx_en = 1'b1; cur_time = 32'd0; mac_rx_data = 8'd0;
        mac_rx_dvld = 1'b0; mac_rx_goodframe = 1'b0; mac_rx_badframe = 1'b0;
        repeat (3) @(posedge rx_clk);
        @(negedge rx_clk);
        compared++;
        if ({result_valid, result_seq, result_delay, cnt_good, cnt_bad, cnt_ignored, cnt_seq_err} !== '0) begin
            mismatched++;
            $display("FAIL reset_state: valid=%b seq=%h delay=%h good=%0d bad=%0d ign=%0d serr=%0d, required all 0",
                     result_valid, result_seq, result_delay, cnt_good, cnt_bad, cnt_ignored, cnt_seq_err);
        end
        @(posedge rx_clk); #1;
        reset = 1'b1;
        @(posedge rx_clk); #1;
    endtask

    task automatic test_basic();
        send_frame(16'h88B5, 16'h0005, 32'd400, 64, 32'd1000, c_GOOD, 1'b1, -1, -1, 1'b1);
        compared++;
        if (cnt_good !== 16'd1 || cnt_seq_err !== 16'd0 || result_delay !== 32'd600) begin
            mismatched++;
            $display("FAIL basic: good=%0d serr=%0d delay=%0d, required 1 0 600", cnt_good, cnt_seq_err, result_delay);
        end
    endtask

    task automatic test_seq();
        send_frame(16'h88B5, 16'h0006, 32'd100, 64, 32'd150, c_GOOD, 1'b1, -1, -1, 1'b0);
        send_frame(16'h88B5, 16'h0008, 32'd200, 64, 32'd270, c_GOOD, 1'b1, -1, -1, 1'b0);
        compared++;
        if (cnt_good !== 16'd3 || cnt_seq_err !== 16'd1) begin
            mismatched++;
            $display("FAIL seq_gap: good=%0d serr=%0d, required 3 1", cnt_good, cnt_seq_err);
        end
        // FFFF after 8 is a gap; 0000 after FFFF is continuous
        send_frame(16'h88B5, 16'hFFFF, 32'd10, 60, 32'd20, c_GOOD, 1'b1, -1, -1, 1'b0);
        send_frame(16'h88B5, 16'h0000, 32'd30, 60, 32'd45, c_GOOD, 1'b1, -1, -1, 1'b0);
        compared++;
        if (cnt_good !== 16'd5 || cnt_seq_err !== 16'd2) begin
            mismatched++;
            $display("FAIL seq_wrap: good=%0d serr=%0d, required 5 2", cnt_good, cnt_seq_err);
        end
    endtask

    task automatic test_delay_wrap();
        send_frame(16'h88B5, 16'h0001, 32'hFFFF_FFF0, 64, 32'h0000_0010, c_GOOD, 1'b1, -1, -1, 1'b0);
        compared++;
        if (result_delay !== 32'h20 || cnt_good !== 16'd6 || cnt_seq_err !== 16'd2) begin
            mismatched++;
            $display("FAIL delay_wrap: delay=%h good=%0d serr=%0d, required 00000020 6 2",
                     result_delay, cnt_good, cnt_seq_err);
        end
    endtask

    task automatic test_ignored();
        send_frame(16'h0800, 16'h0002, 32'd0, 64, 32'd5, c_GOOD, 1'b0, -1, -1, 1'b0);
        send_frame(16'h88B5, 16'h0002, 32'd0, 18, 32'd5, c_GOOD, 1'b0, -1, -1, 1'b0);
        send_frame(16'h88B5, 16'h0002, 32'd0, 64, 32'd5, c_BAD,  1'b0, -1, -1, 1'b0);
        compared++;
        if (cnt_ignored !== 16'd2 || cnt_bad !== 16'd1 || cnt_good !== 16'd6) begin
            mismatched++;
            $display("FAIL ignored: ign=%0d bad=%0d good=%0d, required 2 1 6", cnt_ignored, cnt_bad, cnt_good);
        end
        send_frame(16'h88B5, 16'h0002, 32'd0, 64, 32'd5, c_BOTH, 1'b0, -1, -1, 1'b0);
        compared++;
        if (cnt_bad !== 16'd2 || cnt_good !== 16'd6 || cnt_ignored !== 16'd2) begin
            mismatched++;
            $display("FAIL bad_and_good: bad=%0d good=%0d ign=%0d, required 2 6 2", cnt_bad, cnt_good, cnt_ignored);
        end
    endtask

    task automatic test_disabled();
        conf_rx_en = 1'b0;
        send_frame(16'h88B5, 16'h0002, 32'd0, 64, 32'd5, c_GOOD, 1'b0, 5, -1, 1'b0);
        compared++;
        if (cnt_good !== 16'd6 || cnt_bad !== 16'd2 || cnt_ignored !== 16'd2 || cnt_seq_err !== 16'd2) begin
            mismatched++;
            $display("FAIL disabled: good=%0d bad=%0d ign=%0d serr=%0d, required 6 2 2 2",
                     cnt_good, cnt_bad, cnt_ignored, cnt_seq_err);
        end
        conf_rx_en = 1'b1;
    endtask

    task automatic test_async_reset();
        send_frame(16'h88B5, 16'h0064, 32'd0, 64, 32'd5, c_GOOD, 1'b0, -1, 16, 1'b0);
        compared++;
        if ({cnt_good, cnt_bad, cnt_ignored, cnt_seq_err} !== 64'd0 || result_seq !== 16'd0) begin
            mismatched++;
            $display("FAIL mid_frame_reset: good=%0d bad=%0d ign=%0d serr=%0d seq=%h, required all 0",
                     cnt_good, cnt_bad, cnt_ignored, cnt_seq_err, result_seq);
        end
        send_frame(16'h88B5, 16'h0009, 32'd4000, 64, 32'd5000, c_GOOD, 1'b1, -1, -1, 1'b0);
        compared++;
        if (cnt_good !== 16'd1 || cnt_seq_err !== 16'd0 || cnt_bad !== 16'd0 || cnt_ignored !== 16'd0) begin
            mismatched++;
            $display("FAIL after_reset: good=%0d serr=%0d bad=%0d ign=%0d, required 1 0 0 0",
                     cnt_good, cnt_seq_err, cnt_bad, cnt_ignored);
        end
    endtask

    task automatic test_back_to_back();
        // First frame never gets a status; the next frame's first byte abandons it
        send_frame(16'h88B5, 16'h000A, 32'd10, 64, 32'd90, c_NONE, 1'b0, -1, -1, 1'b0);
        send_frame(16'h88B5, 16'h000B, 32'd10, 64, 32'd77, c_GOOD, 1'b1, -1, -1, 1'b0);
        compared++;
        if (cnt_ignored !== 16'd1 || cnt_good !== 16'd2 || cnt_seq_err !== 16'd1) begin
            mismatched++;
            $display("FAIL missing_status: ign=%0d good=%0d serr=%0d, required 1 2 1",
                     cnt_ignored, cnt_good, cnt_seq_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_seq();
        test_delay_wrap();
        test_ignored();
        test_disabled();
        test_async_reset();
        test_back_to_back();
        repeat (4) @(posedge rx_clk);
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL missing_results: %0d results outstanding, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/frame_receiver.md
Name: frame_receiver

Overview:
- Client-side consumer of the gigabit MAC RX interface; it is the receive-end counterpart of frame_sender.
- Parses delay-test frames: Ethertype match, 16-bit sequence number, 32-bit transmit timestamp.
- Computes one-way delay against a local time base and checks sequence continuity.
- Keeps saturating statistics counters for the delay_tester datapath, in the MAC rx_clk domain.

Parameters:
- ETHERTYPE, 16'h88B5, Ethertype that identifies a test frame.
- TS_WIDTH, 32, width of timestamps and of the delay result.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- rx_clk  in  1  MAC receive clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- conf_rx_en  in  1  receiver enable; sampled only at frame start.
- cur_time  in  TS_WIDTH  free-running local time, synchronous to rx_clk.
- mac_rx_data  in  8  received byte.
- mac_rx_dvld  in  1  byte valid.
- mac_rx_goodframe  in  1  1-cycle pulse: previous frame had good CRC and length.
- mac_rx_badframe  in  1  1-cycle pulse: previous frame was bad.
- result_valid  out  1  1-cycle pulse: a new delay result is available.
- result_seq  out  16  sequence number of the last good test frame.
- result_delay  out  TS_WIDTH  (rx_time - tx_time) mod 2^TS_WIDTH.
- cnt_good  out  CNT_WIDTH  good test frames.
- cnt_bad  out  CNT_WIDTH  badframe events.
- cnt_ignored  out  CNT_WIDTH  good frames that are not test frames, short frames, or abandoned frames.
- cnt_seq_err  out  CNT_WIDTH  sequence discontinuities.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal `seq_init` = 0.
- Frame layout, byte index from the first dvld byte (big-endian fields):
  - 0-11: MAC addresses, not checked.
  - 12-13: Ethertype.
  - 14-15: sequence number.
  - 16-19: tx timestamp.
  - 20 onward: ignored.
- Byte counter: 11 bits, saturates at 2047, cleared in IDLE.
- Frame start = first cycle with dvld=1 in IDLE.
  - At frame start, latch cur_time into rx_time.
  - If conf_rx_en=0 at frame start, go to DISCARD.
- FSM states:
  - IDLE: dvld -> HDR (byte 0 consumed), or DISCARD if disabled.
  - HDR: bytes 1-13. At byte 13 compare the Ethertype: mismatch -> flag not-test, go to DRAIN; match -> SEQ.
  - SEQ: bytes 14-15 shifted into the seq register -> TS.
  - TS: bytes 16-19 shifted into tx_time -> DRAIN.
  - DRAIN: further dvld bytes are ignored; dvld=0 -> WAIT_STATUS.
  - WAIT_STATUS: waits for a goodframe/badframe pulse, then returns to IDLE.
  - DISCARD: same as DRAIN followed by WAIT_STATUS, but no counters are updated on status.
- If dvld drops before byte 19, mark the frame short, go to WAIT_STATUS, and preserve the partial field values.
- Status handling in WAIT_STATUS:
  - badframe (including badframe and goodframe asserted together): cnt_bad+1, no result.
  - goodframe on a short or not-test frame: cnt_ignored+1.
  - goodframe on a complete test frame: cnt_good+1, then on the next cycle:
    - result_valid=1, result_seq=seq, result_delay=rx_time-tx_time (modular subtraction, no sign).
    - Sequence check: if seq_init=1 and seq != expected, cnt_seq_err+1.
    - expected = seq+1 (wraps FFFF->0000); seq_init set to 1.
  - Latency: result_valid one cycle after the goodframe cycle.
- Status pulse arriving in IDLE, HDR, SEQ, TS or DRAIN: ignored (no counter change).
- dvld=1 in WAIT_STATUS (missing status): cnt_ignored+1 for the abandoned frame; treat the cycle as a new frame start.
- All counters saturate at all-ones and never wrap.
- result_seq and result_delay hold their values until the next result.
- Asynchronous reset mid-frame: immediate return to reset values; the next frame start is parsed normally.

Test Plan:
1. Reset release, conf_rx_en=1, cur_time=1000, frame with Ethertype 88B5, seq 0x0005, tx_ts 400, 64 bytes, then goodframe -> one cycle later result_valid=1, result_seq=5, result_delay=600, cnt_good=1, cnt_seq_err=0.
2. Frames seq 5, 6, 8, all good -> cnt_good=3, cnt_seq_err=1; seq FFFF followed by 0000 -> no error.
3. tx_ts=FFFFFFF0, rx cur_time=00000010 -> result_delay=0x20 (wrap-around).
4. Ethertype 0800 good frame; 18-byte test frame good; test frame followed by badframe -> cnt_ignored=2, cnt_bad=1, result_valid never asserted.
5. conf_rx_en=0 at frame start, goodframe -> no counter change; conf_rx_en set to 1 mid-frame has no effect on that frame.
6. Assert reset at byte 16 of a test frame, release, send a valid frame seq 9 -> all counters count only the new frame, and no cnt_seq_err (seq_init cleared by reset).
